// File: rtl/axi4lite_reg_pkg.sv
// Shared response codes, FSM state types and decode helpers for the
// AXI4-Lite control-register slave.
package axi4lite_reg_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Byte address bits below this one select a lane inside a 32-bit word.
   localparam int ADDR_LSB = 2;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WAIT,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

   function automatic logic [1:0] resp_for_hit(input logic hit);
      return hit ? RESP_OKAY : RESP_SLVERR;
   endfunction

endpackage

// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register slave.
interface axi4lite_reg_slave_if #(
   parameter int C_ADDR_WIDTH = 6,
   parameter int C_DATA_WIDTH = 32
);

   logic [C_ADDR_WIDTH-1:0]   AWADDR;
   logic [2:0]                AWPROT;
   logic                      AWVALID;
   logic                      AWREADY;

   logic [C_DATA_WIDTH-1:0]   WDATA;
   logic [C_DATA_WIDTH/8-1:0] WSTRB;
   logic                      WVALID;
   logic                      WREADY;

   logic [1:0]                BRESP;
   logic                      BVALID;
   logic                      BREADY;

   logic [C_ADDR_WIDTH-1:0]   ARADDR;
   logic [2:0]                ARPROT;
   logic                      ARVALID;
   logic                      ARREADY;

   logic [C_DATA_WIDTH-1:0]   RDATA;
   logic [1:0]                RRESP;
   logic                      RVALID;
   logic                      RREADY;

   modport slave (
      input  AWADDR, AWPROT, AWVALID,
      output AWREADY,
      input  WDATA, WSTRB, WVALID,
      output WREADY,
      output BRESP, BVALID,
      input  BREADY,
      input  ARADDR, ARPROT, ARVALID,
      output ARREADY,
      output RDATA, RRESP, RVALID,
      input  RREADY
   );

   modport master (
      output AWADDR, AWPROT, AWVALID,
      input  AWREADY,
      output WDATA, WSTRB, WVALID,
      input  WREADY,
      input  BRESP, BVALID,
      output BREADY,
      output ARADDR, ARPROT, ARVALID,
      input  ARREADY,
      input  RDATA, RRESP, RVALID,
      output RREADY
   );

endinterface

// File: rtl/axi4lite_reg_bank.sv
// Byte-lane writable bank of 32-bit control registers with a combinational
// read port and a flat copy of every register for user logic.
module axi4lite_reg_bank #(
   parameter int C_NUM_REGS  = 4,
   parameter int C_IDX_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [3:0]                 wr_be,
   input  logic [C_IDX_WIDTH-1:0]     wr_idx,
   input  logic [31:0]                wr_data,
   input  logic [C_IDX_WIDTH-1:0]     rd_idx,
   output logic [31:0]                rd_data,
   output logic [C_NUM_REGS*32-1:0]   reg_out
);

   logic [31:0] regs [C_NUM_REGS];

   // NOTE: this storage is reset on purpose; reg_out feeds user logic
   // directly, so it must come out of reset at a known value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < C_NUM_REGS; k++) begin
            regs[k] <= '0;
         end
      end else begin
         for (int k = 0; k < C_NUM_REGS; k++) begin
            for (int b = 0; b < 4; b++) begin
               if (wr_be[b] && (32'(wr_idx) == k)) begin
                  regs[k][8*b +: 8] <= wr_data[8*b +: 8];
               end
            end
         end
      end
   end

   // Out-of-range indices read as zero; the caller also flags them.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < C_NUM_REGS; k++) begin
         if (32'(rd_idx) == k) begin
            rd_data = regs[k];
         end
      end
   end

   for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_flat
      assign reg_out[32*k +: 32] = regs[k];
   end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite responder for a small control-register bank: independent write
// and read FSMs, one outstanding transaction per channel, SLVERR off the end.
module axi4lite_reg_slave
   import axi4lite_reg_pkg::*;
#(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_ADDR_WIDTH = 6,
   parameter int C_NUM_REGS   = 4
) (
   input  logic                             ACLK,
   input  logic                             ARESET,
   axi4lite_reg_slave_if.slave              s_axi,
   output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out
);

   localparam int IDX_W = C_ADDR_WIDTH - ADDR_LSB;

   wr_state_t        wr_state, wr_next;
   rd_state_t        rd_state, rd_next;

   logic             ready_en;
   logic             aw_held, w_held;
   logic [IDX_W-1:0] aw_idx_q;
   logic [31:0]      wdata_q;
   logic [3:0]       wstrb_q;
   logic [1:0]       bresp_q, rresp_q;
   logic [31:0]      rdata_q;

   logic             awready, wready, bvalid, arready, rvalid;
   logic             aw_fire, w_fire, ar_fire, wr_commit;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [31:0]      wr_data, bank_rd_data;
   logic [3:0]       wr_strb, wr_be;
   logic             wr_hit, rd_hit;

   assign aw_fire = s_axi.AWVALID && awready;
   assign w_fire  = s_axi.WVALID  && wready;
   assign ar_fire = s_axi.ARVALID && arready;

   // The commit uses whichever half was captured earlier and the live bus
   // for the half arriving now, so the bank updates on the completing edge.
   assign wr_idx    = aw_held ? aw_idx_q : s_axi.AWADDR[C_ADDR_WIDTH-1:ADDR_LSB];
   assign wr_data   = w_held  ? wdata_q  : s_axi.WDATA;
   assign wr_strb   = w_held  ? wstrb_q  : s_axi.WSTRB;
   assign wr_commit = (aw_fire || aw_held) && (w_fire || w_held);
   assign wr_hit    = 32'(wr_idx) < C_NUM_REGS;
   assign wr_be     = (wr_commit && wr_hit) ? wr_strb : 4'b0000;

   assign rd_idx = s_axi.ARADDR[C_ADDR_WIDTH-1:ADDR_LSB];
   assign rd_hit = 32'(rd_idx) < C_NUM_REGS;

   axi4lite_reg_bank #(
      .C_NUM_REGS  (C_NUM_REGS),
      .C_IDX_WIDTH (IDX_W)
   ) u_bank (
      .clk     (ACLK),
      .rst     (ARESET),
      .wr_be   (wr_be),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .rd_idx  (rd_idx),
      .rd_data (bank_rd_data),
      .reg_out (reg_out)
   );

   // NOTE: all state uses <= so every flop sees pre-edge values; that is
   // what makes a same-edge read return the value before a write commit.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_state <= W_IDLE;
         rd_state <= R_IDLE;
         ready_en <= 1'b0;
      end else begin
         wr_state <= wr_next;
         rd_state <= rd_next;
         ready_en <= 1'b1;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      wr_next = wr_state;
      unique case (wr_state)
         W_IDLE: begin
            if (wr_commit)              wr_next = W_RESP;
            else if (aw_fire || w_fire) wr_next = W_WAIT;
         end
         W_WAIT: if (wr_commit)      wr_next = W_RESP;
         W_RESP: if (s_axi.BREADY)   wr_next = W_IDLE;
         default:                    wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      rd_next = rd_state;
      unique case (rd_state)
         R_IDLE:  if (ar_fire)      rd_next = R_DATA;
         R_DATA:  if (s_axi.RREADY) rd_next = R_IDLE;
         default:                   rd_next = R_IDLE;
      endcase
   end

   always_comb begin
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      unique case (wr_state)
         W_IDLE, W_WAIT: begin
            awready = ready_en && !aw_held;
            wready  = ready_en && !w_held;
         end
         W_RESP:  bvalid = 1'b1;
         default: ;
      endcase
      arready = ready_en && (rd_state == R_IDLE);
      rvalid  = (rd_state == R_DATA);
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         aw_idx_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp_q  <= RESP_OKAY;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else begin
         if (wr_commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp_q <= resp_for_hit(wr_hit);
         end else begin
            if (aw_fire) begin
               aw_held  <= 1'b1;
               aw_idx_q <= s_axi.AWADDR[C_ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_fire) begin
               w_held  <= 1'b1;
               wdata_q <= s_axi.WDATA;
               wstrb_q <= s_axi.WSTRB;
            end
         end
         if (ar_fire) begin
            rdata_q <= rd_hit ? bank_rd_data : 32'h0;
            rresp_q <= resp_for_hit(rd_hit);
         end
      end
   end

   assign s_axi.AWREADY = awready;
   assign s_axi.WREADY  = wready;
   assign s_axi.BVALID  = bvalid;
   assign s_axi.BRESP   = bresp_q;
   assign s_axi.ARREADY = arready;
   assign s_axi.RVALID  = rvalid;
   assign s_axi.RDATA   = rdata_q;
   assign s_axi.RRESP   = rresp_q;

   // Protection bits and sub-word address bits carry no meaning here.
   logic unused_bits;
   assign unused_bits = &{1'b0, s_axi.AWPROT, s_axi.ARPROT,
                          s_axi.AWADDR[ADDR_LSB-1:0], s_axi.ARADDR[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave: hand-computed expectations for
// reset, full/partial writes, handshake ordering, stalls, SLVERR and reset.
module tb_axi4lite_reg_slave;
   import axi4lite_reg_pkg::*;

   logic         clk = 1'b0;
   logic         areset;
   logic [127:0] reg_out;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   axi4lite_reg_slave_if #(.C_ADDR_WIDTH(6), .C_DATA_WIDTH(32)) bus ();

   axi4lite_reg_slave #(
      .C_DATA_WIDTH (32),
      .C_ADDR_WIDTH (6),
      .C_NUM_REGS   (4)
   ) dut (
      .ACLK    (clk),
      .ARESET  (areset),
      .s_axi   (bus),
      .reg_out (reg_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output bit ok);
      int n;
      bit aw_d, w_d, aw_hs, w_hs;
      ok = 1'b1; n = 0; aw_d = 1'b0; w_d = 1'b0;
      bus.AWADDR = addr; bus.AWVALID = 1'b1;
      bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
      bus.BREADY = 1'b0;
      while (!(aw_d && w_d) && n < 20) begin
         aw_hs = bus.AWVALID && bus.AWREADY;
         w_hs  = bus.WVALID && bus.WREADY;
         tick(); n++;
         if (aw_hs) begin aw_d = 1'b1; bus.AWVALID = 1'b0; end
         if (w_hs)  begin w_d  = 1'b1; bus.WVALID  = 1'b0; end
      end
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      if (!(aw_d && w_d)) ok = 1'b0;
      n = 0;
      while (!bus.BVALID && n < 20) begin tick(); n++; end
      if (!bus.BVALID) ok = 1'b0;
      resp = bus.BRESP;
      bus.BREADY = 1'b1;
      tick();
      bus.BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output bit ok);
      int n;
      bit ar_d, ar_hs;
      ok = 1'b1; n = 0; ar_d = 1'b0;
      bus.ARADDR = addr; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
      while (!ar_d && n < 20) begin
         ar_hs = bus.ARVALID && bus.ARREADY;
         tick(); n++;
         if (ar_hs) begin ar_d = 1'b1; bus.ARVALID = 1'b0; end
      end
      bus.ARVALID = 1'b0;
      if (!ar_d) ok = 1'b0;
      n = 0;
      while (!bus.RVALID && n < 20) begin tick(); n++; end
      if (!bus.RVALID) ok = 1'b0;
      data = bus.RDATA;
      resp = bus.RRESP;
      bus.RREADY = 1'b1;
      tick();
      bus.RREADY = 1'b0;
   endtask

   task automatic test_reset();
      vectors++;
      if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_readies: got %b expected 000", {bus.AWREADY, bus.WREADY, bus.ARREADY});
      end
      vectors++;
      if ({bus.BVALID, bus.RVALID} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_valids: got %b expected 00", {bus.BVALID, bus.RVALID});
      end
      vectors++;
      if (reg_out !== 128'h0) begin
         miscompares++;
         $display("FAIL reset_reg_out: got %h expected 0", reg_out);
      end
      areset = 1'b0;
      tick();
      vectors++;
      if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
         miscompares++;
         $display("FAIL ready_after_reset: got %b expected 111", {bus.AWREADY, bus.WREADY, bus.ARREADY});
      end
   endtask

   task automatic test_basic_rw();
      logic [1:0]  resp;
      logic [31:0] data;
      bit          ok;
      for (int i = 0; i < 4; i++) begin
         axi_write(6'(i * 4), 32'(i + 1), 4'hF, resp, ok);
         vectors++;
         if (!ok || resp !== RESP_OKAY) begin
            miscompares++;
            $display("FAIL basic_write[%0d]: got ok=%0d resp=%b expected ok=1 resp=00", i, ok, resp);
         end
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(6'(i * 4), data, resp, ok);
         vectors++;
         if (!ok || resp !== RESP_OKAY || data !== 32'(i + 1)) begin
            miscompares++;
            $display("FAIL basic_read[%0d]: got ok=%0d resp=%b data=%h expected ok=1 resp=00 data=%h",
                     i, ok, resp, data, 32'(i + 1));
         end
      end
      vectors++;
      if (reg_out !== 128'h00000004_00000003_00000002_00000001) begin
         miscompares++;
         $display("FAIL basic_reg_out: got %h expected 00000004000000030000000200000001", reg_out);
      end
   endtask

   task automatic test_strobe();
      logic [1:0]  resp;
      logic [31:0] data;
      bit          ok;
      axi_write(6'h04, 32'h00000002, 4'hF, resp, ok);
      axi_write(6'h04, 32'hAABBCCDD, 4'b0011, resp, ok);
      axi_read(6'h04, data, resp, ok);
      vectors++;
      if (!ok || data !== 32'h0000CCDD) begin
         miscompares++;
         $display("FAIL strobe_low_half: got %h expected 0000ccdd", data);
      end
      axi_write(6'h04, 32'h12345678, 4'b1100, resp, ok);
      // Sub-word address bits must be ignored: 0x7 selects word 1.
      axi_read(6'h07, data, resp, ok);
      vectors++;
      if (!ok || data !== 32'h1234CCDD) begin
         miscompares++;
         $display("FAIL strobe_high_half: got %h expected 1234ccdd", data);
      end
      axi_write(6'h08, 32'hFFFFFFFF, 4'b0000, resp, ok);
      vectors++;
      if (!ok || resp !== RESP_OKAY) begin
         miscompares++;
         $display("FAIL strobe_zero_resp: got %b expected 00", resp);
      end
      axi_read(6'h08, data, resp, ok);
      vectors++;
      if (!ok || data !== 32'h00000003) begin
         miscompares++;
         $display("FAIL strobe_zero_data: got %h expected 00000003", data);
      end
   endtask

   task automatic test_w_before_aw();
      bus.WDATA = 32'h00000055; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      bus.AWVALID = 1'b0; bus.BREADY = 1'b0;
      tick();
      bus.WVALID = 1'b0;
      vectors++;
      if ({bus.WREADY, bus.AWREADY} !== 2'b01) begin
         miscompares++;
         $display("FAIL w_first_readies: got %b expected 01", {bus.WREADY, bus.AWREADY});
      end
      tick(); tick();
      vectors++;
      if (bus.BVALID !== 1'b0 || reg_out[127:96] !== 32'h4) begin
         miscompares++;
         $display("FAIL w_first_wait: got bvalid=%b reg3=%h expected 0 00000004", bus.BVALID, reg_out[127:96]);
      end
      bus.AWADDR = 6'h0C; bus.AWVALID = 1'b1;
      tick();
      bus.AWVALID = 1'b0;
      vectors++;
      if (bus.BVALID !== 1'b1 || bus.BRESP !== RESP_OKAY || reg_out[127:96] !== 32'h55 || bus.AWREADY !== 1'b0) begin
         miscompares++;
         $display("FAIL w_first_commit: got bvalid=%b bresp=%b reg3=%h awready=%b expected 1 00 00000055 0",
                  bus.BVALID, bus.BRESP, reg_out[127:96], bus.AWREADY);
      end
      bus.BREADY = 1'b1;
      tick();
      bus.BREADY = 1'b0;
      tick();
      vectors++;
      if (bus.BVALID !== 1'b0 || reg_out[127:96] !== 32'h55) begin
         miscompares++;
         $display("FAIL w_first_done: got bvalid=%b reg3=%h expected 0 00000055", bus.BVALID, reg_out[127:96]);
      end
   endtask

   task automatic test_bready_stall();
      bus.AWADDR = 6'h00; bus.AWVALID = 1'b1;
      bus.WDATA = 32'h11111111; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      bus.BREADY = 1'b0;
      tick();
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      vectors++;
      if (reg_out[31:0] !== 32'h11111111) begin
         miscompares++;
         $display("FAIL bstall_commit: got %h expected 11111111", reg_out[31:0]);
      end
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (bus.BVALID !== 1'b1 || bus.BRESP !== RESP_OKAY || bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL bstall_hold[%0d]: got bvalid=%b bresp=%b awready=%b wready=%b expected 1 00 0 0",
                     i, bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY);
         end
         tick();
      end
      bus.BREADY = 1'b1;
      tick();
      bus.BREADY = 1'b0;
      vectors++;
      if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1) begin
         miscompares++;
         $display("FAIL bstall_release: got bvalid=%b awready=%b wready=%b expected 0 1 1",
                  bus.BVALID, bus.AWREADY, bus.WREADY);
      end
      bus.AWADDR = 6'h00; bus.AWVALID = 1'b1;
      bus.WDATA = 32'h22222222; bus.WVALID = 1'b1;
      tick();
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      vectors++;
      if (bus.BVALID !== 1'b1 || reg_out[31:0] !== 32'h22222222) begin
         miscompares++;
         $display("FAIL bstall_next_write: got bvalid=%b reg0=%h expected 1 22222222", bus.BVALID, reg_out[31:0]);
      end
      bus.BREADY = 1'b1;
      tick();
      bus.BREADY = 1'b0;
   endtask

   task automatic test_rready_stall();
      bus.ARADDR = 6'h00; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
      tick();
      bus.ARVALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (bus.RVALID !== 1'b1 || bus.RDATA !== 32'h22222222 || bus.RRESP !== RESP_OKAY || bus.ARREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL rstall_hold[%0d]: got rvalid=%b rdata=%h rresp=%b arready=%b expected 1 22222222 00 0",
                     i, bus.RVALID, bus.RDATA, bus.RRESP, bus.ARREADY);
         end
         tick();
      end
      bus.RREADY = 1'b1;
      tick();
      bus.RREADY = 1'b0;
      vectors++;
      if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b1) begin
         miscompares++;
         $display("FAIL rstall_release: got rvalid=%b arready=%b expected 0 1", bus.RVALID, bus.ARREADY);
      end
   endtask

   task automatic test_same_edge();
      bus.AWADDR = 6'h08; bus.AWVALID = 1'b1;
      bus.WDATA = 32'h00000099; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      bus.ARADDR = 6'h08; bus.ARVALID = 1'b1;
      bus.BREADY = 1'b0; bus.RREADY = 1'b0;
      tick();
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
      vectors++;
      if (bus.RDATA !== 32'h3 || bus.BVALID !== 1'b1 || bus.RVALID !== 1'b1 || reg_out[95:64] !== 32'h99) begin
         miscompares++;
         $display("FAIL same_edge: got rdata=%h bvalid=%b rvalid=%b reg2=%h expected 00000003 1 1 00000099",
                  bus.RDATA, bus.BVALID, bus.RVALID, reg_out[95:64]);
      end
      bus.BREADY = 1'b1; bus.RREADY = 1'b1;
      tick();
      bus.BREADY = 1'b0; bus.RREADY = 1'b0;
      vectors++;
      if ({bus.BVALID, bus.RVALID} !== 2'b00) begin
         miscompares++;
         $display("FAIL same_edge_done: got %b expected 00", {bus.BVALID, bus.RVALID});
      end
   endtask

   task automatic test_slverr();
      logic [1:0]   resp;
      logic [31:0]  data;
      bit           ok;
      logic [127:0] exp_regs;
      exp_regs = 128'h00000055_00000099_1234CCDD_22222222;
      axi_write(6'h10, 32'hDEADBEEF, 4'hF, resp, ok);
      vectors++;
      if (!ok || resp !== RESP_SLVERR) begin
         miscompares++;
         $display("FAIL slverr_write_resp: got ok=%0d resp=%b expected ok=1 resp=10", ok, resp);
      end
      vectors++;
      if (reg_out !== exp_regs) begin
         miscompares++;
         $display("FAIL slverr_no_change: got %h expected %h", reg_out, exp_regs);
      end
      axi_read(6'h3C, data, resp, ok);
      vectors++;
      if (!ok || resp !== RESP_SLVERR || data !== 32'h0) begin
         miscompares++;
         $display("FAIL slverr_read: got ok=%0d resp=%b data=%h expected ok=1 resp=10 data=0", ok, resp, data);
      end
      axi_read(6'h0C, data, resp, ok);
      vectors++;
      if (!ok || resp !== RESP_OKAY || data !== 32'h55) begin
         miscompares++;
         $display("FAIL last_word_read: got ok=%0d resp=%b data=%h expected ok=1 resp=00 data=00000055", ok, resp, data);
      end
   endtask

   task automatic test_reset_inflight();
      logic [1:0]  resp;
      logic [31:0] data;
      bit          ok;
      bus.AWADDR = 6'h08; bus.AWVALID = 1'b1;
      bus.WDATA = 32'h0BADF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      bus.ARADDR = 6'h04; bus.ARVALID = 1'b1;
      bus.BREADY = 1'b0; bus.RREADY = 1'b0;
      tick();
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
      vectors++;
      if ({bus.BVALID, bus.RVALID} !== 2'b11) begin
         miscompares++;
         $display("FAIL inflight_setup: got %b expected 11", {bus.BVALID, bus.RVALID});
      end
      areset = 1'b1;
      tick();
      vectors++;
      if ({bus.BVALID, bus.RVALID} !== 2'b00 || reg_out !== 128'h0 || bus.RDATA !== 32'h0 || bus.BRESP !== 2'b00 ||
          {bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b000) begin
         miscompares++;
         $display("FAIL inflight_reset: got valids=%b reg_out=%h rdata=%h bresp=%b readies=%b expected 00 0 0 00 000",
                  {bus.BVALID, bus.RVALID}, reg_out, bus.RDATA, bus.BRESP, {bus.AWREADY, bus.WREADY, bus.ARREADY});
      end
      areset = 1'b0;
      tick();
      axi_write(6'h08, 32'hCAFEF00D, 4'hF, resp, ok);
      vectors++;
      if (!ok || resp !== RESP_OKAY) begin
         miscompares++;
         $display("FAIL post_reset_write: got ok=%0d resp=%b expected ok=1 resp=00", ok, resp);
      end
      axi_read(6'h08, data, resp, ok);
      vectors++;
      if (!ok || resp !== RESP_OKAY || data !== 32'hCAFEF00D) begin
         miscompares++;
         $display("FAIL post_reset_read: got ok=%0d resp=%b data=%h expected ok=1 resp=00 data=cafef00d", ok, resp, data);
      end
      vectors++;
      if (reg_out !== 128'h00000000_CAFEF00D_00000000_00000000) begin
         miscompares++;
         $display("FAIL post_reset_reg_out: got %h expected 00000000cafef00d0000000000000000", reg_out);
      end
   endtask

   initial begin
      areset = 1'b1;
      bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
      bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
      bus.BREADY = 1'b0;
      bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0;
      bus.RREADY = 1'b0;
      repeat (3) tick();
      test_reset();
      test_basic_rw();
      test_strobe();
      test_w_before_aw();
      test_bready_stall();
      test_rready_stall();
      test_same_edge();
      test_slverr();
      test_reset_inflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
